// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// uart_pkg -- state encoding and frame constants shared by the UART transmitter and receiver. Rev 1.0
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } uart_state_e;
`endif

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// uart_baud_tick -- counts enabled clocks 0..DIV-1 and pulses tick on the last one. Rev 1.0
module uart_baud_tick #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9_600
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;
  logic          at_last;

  assign at_last = (count == CW'(DIV - 1));
  // A clear restarts the bit period, so it must also suppress a coincident tick.
  assign tick    = enable && !clear && at_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (at_last) count <= '0;
      else         count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// uart_tx -- byte-wide UART transmitter, 8N1; define UART_TX_PARITY_EN for an even parity bit (8E1).
// Rev 1.0
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9_600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       TxD,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  uart_state_e state, state_next;
  logic [7:0]  data_reg, data_next;
  logic [2:0]  bit_idx, bit_next;
  logic        txd_next, ready_next, busy_next;
  logic        clear, tick;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      TxD      <= IDLE_LEVEL;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      bit_idx  <= 3'd0;
      data_reg <= 8'd0;
    end else begin
      state    <= state_next;
      TxD      <= txd_next;
      tx_ready <= ready_next;
      busy     <= busy_next;
      bit_idx  <= bit_next;
      data_reg <= data_next;
    end
  end

  // Every transition waits on tick or an enabled accept, so enable=0 freezes all state.
  always_comb begin
    state_next = state;
    data_next  = data_reg;
    bit_next   = bit_idx;
    txd_next   = TxD;
    ready_next = tx_ready;
    busy_next  = busy;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        txd_next   = IDLE_LEVEL;
        ready_next = 1'b1;
        busy_next  = 1'b0;
        if (enable && tx_valid && tx_ready) begin
          data_next  = tx_data;
          bit_next   = 3'd0;
          clear      = 1'b1;
          state_next = START;
          txd_next   = 1'b0;
          ready_next = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          txd_next   = data_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          bit_next = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            txd_next   = ^data_reg;
`else
            state_next = STOP;
            txd_next   = IDLE_LEVEL;
`endif
          end else begin
            txd_next = data_reg[bit_next];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          txd_next   = IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          txd_next   = IDLE_LEVEL;
          ready_next = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = IDLE_LEVEL;
        ready_next = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
